mem_arbiter: RTL and testbench

Shares the single data port of the memory controller between `NREQ` requesters, for example the CPU load/store unit and a debug/DMA loader. Runs one transaction at a time through a three-state sequencer. Grants are round-robin. Each transaction is checked for mapping and alignment before it reaches the bus, so a faulty request never writes. Sits between the requesters and `memory_controller`; the instruction port (`iaddr`/`inst`) is not routed through this block.

---
 rtl/mem_arbiter_pkg.sv | 36 +++
 rtl/mem_arbiter_rr_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the data-port arbiter.
// Holds sequencer states, write-enable bit positions and the request check.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int WE_WORD = 0;
  localparam int WE_HALF = 1;
  localparam int WE_BYTE = 2;

  localparam logic [3:0] LAST_MAPPED_REGION = 4'h3;

  // Reads may be misaligned; only writes have alignment rules.
  function automatic logic req_bad(
    input logic [2:0] we,
    input logic [3:0] region,
    input logic [1:0] low
  );
    logic multi;
    logic unmapped;
    logic half_mis;
    logic word_mis;
    multi = (we[WE_WORD] & we[WE_HALF])
          | (we[WE_WORD] & we[WE_BYTE])
          | (we[WE_HALF] & we[WE_BYTE]);
    unmapped = region > LAST_MAPPED_REGION;
    half_mis = we[WE_HALF] & low[0];
    word_mis = we[WE_WORD] & (low != 2'b00);
    return multi | unmapped | half_mis | word_mis;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin select.
// Picks the first set request at or after rr_ptr, wrapping around.
module rr_pick #(
  parameter  int NREQ = 2,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  int c;

  // Walk from the far end so the candidate nearest rr_ptr is kept last.
  always_comb begin
    gnt = '0;
    idx = '0;
    c   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      c = (int'(rr_ptr) + i) % NREQ;
      if (req[c]) begin
        gnt    = '0;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the memory controller data port.
// One checked transaction at a time: IDLE -> ACCESS -> DONE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [3*NREQ-1:0]    req_we,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [32*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      err,
  output logic [31:0]          rdata,
  output logic                 busy,
  output logic [31:0]          mem_addr,
  output logic [2:0]           mem_write_enable,
  output logic [31:0]          mem_data_in,
  input  logic [31:0]          mem_data_out
);

  state_e      state_q, state_d;
  logic [2:0]  we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic        bad_q, bad_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic [2:0]      sel_we;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt    (pick_gnt),
    .idx    (pick_idx)
  );

  assign sel_we    = req_we[3*int'(pick_idx) +: 3];
  assign sel_addr  = req_addr[32*int'(pick_idx) +: 32];
  assign sel_wdata = req_wdata[32*int'(pick_idx) +: 32];

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    bad_d    = bad_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|pick_gnt) begin
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          idx_d   = pick_idx;
          bad_d   = req_bad(sel_we, sel_addr[31:28], sel_addr[1:0]);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rdata_d = bad_q ? '0 : mem_data_out;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        rr_ptr_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      we_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      bad_q    <= bad_d;
    end
  end

  // Bus and completion outputs decode straight from the state register.
  always_comb begin
    busy             = (state_q == ST_ACCESS) || (state_q == ST_DONE);
    mem_addr         = '0;
    mem_data_in      = '0;
    mem_write_enable = '0;
    ack              = '0;
    err              = '0;
    rdata            = '0;
    if (state_q == ST_ACCESS) begin
      mem_addr         = addr_q;
      mem_data_in      = wdata_q;
      mem_write_enable = bad_q ? 3'b000 : we_q;
    end
    if (state_q == ST_DONE) begin
      rdata = bad_q ? '0 : rdata_q;
      for (int i = 0; i < NREQ; i++) begin
        if (idx_q == IW'(i)) begin
          ack[i] = ~bad_q;
          err[i] = bad_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a byte-addressed memory model.
// Completions are matched in order against expectations queued at issue.
module tb_mem_arbiter;

  localparam int NREQ = 2;

  typedef struct {
    int          idx;
    bit          is_err;
    logic [31:0] rd;
    logic [31:0] m;
    logic [2:0]  we;
    int          wc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req;
  logic [3*NREQ-1:0]  req_we;
  logic [32*NREQ-1:0] req_addr;
  logic [32*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    err;
  logic [31:0]        rdata;
  logic               busy;
  logic [31:0]        mem_addr;
  logic [2:0]         mem_write_enable;
  logic [31:0]        mem_data_in;
  logic [31:0]        mem_data_out;

  mem_arbiter #(.NREQ(NREQ)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .ack              (ack),
    .err              (err),
    .rdata            (rdata),
    .busy             (busy),
    .mem_addr         (mem_addr),
    .mem_write_enable (mem_write_enable),
    .mem_data_in      (mem_data_in),
    .mem_data_out     (mem_data_out)
  );

  // Little-endian memory, combinational read shifted to the byte address.
  logic [7:0] ram [256];
  logic [7:0] ra;
  assign ra = mem_addr[7:0];
  assign mem_data_out = {ram[ra+8'd3], ram[ra+8'd2],
                         ram[ra+8'd1], ram[ra]};

  always @(posedge clk) begin
    case (mem_write_enable)
      3'b001: begin
        ram[ra]       <= mem_data_in[7:0];
        ram[ra+8'd1]  <= mem_data_in[15:8];
        ram[ra+8'd2]  <= mem_data_in[23:16];
        ram[ra+8'd3]  <= mem_data_in[31:24];
      end
      3'b010: begin
        ram[ra]       <= mem_data_in[7:0];
        ram[ra+8'd1]  <= mem_data_in[15:8];
      end
      3'b100: ram[ra] <= mem_data_in[7:0];
      default: ;
    endcase
  end

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [31:0] mon_v;
  int   we_cnt = 0;
  logic [2:0] last_we = 3'b000;
  int   hold_cnt [NREQ];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  task automatic sb_push(int idx, bit e, logic [31:0] rd,
                         logic [31:0] m, logic [2:0] we, int wc);
    exp_t x;
    x.idx = idx; x.is_err = e; x.rd = rd;
    x.m = m; x.we = we; x.wc = wc;
    sb.push_back(x);
  endtask

  task automatic issue(int r, logic [2:0] we, logic [31:0] a,
                       logic [31:0] d, int hold);
    req_we[3*r +: 3]     = we;
    req_addr[32*r +: 32] = a;
    req_wdata[32*r +: 32] = d;
    hold_cnt[r] = hold;
    req[r] = 1'b1;
  endtask

  task automatic wait_empty(int n);
    int k = 0;
    while (sb.size() != 0 && k < n) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    if (sb.size() != 0) begin
      sb.delete();
      req = '0;
    end
  endtask

  task automatic xact(int r, logic [2:0] we, logic [31:0] a,
                      logic [31:0] d, bit e, logic [31:0] rd,
                      logic [31:0] m, int wc);
    @(negedge clk);
    sb_push(r, e, rd, m, we, wc);
    issue(r, we, a, d, 1);
    wait_empty(40);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      we_cnt = 0;
    end else begin
      if (mem_write_enable != 3'b000) begin
        we_cnt++;
        last_we = mem_write_enable;
      end
      if ((ack | err) != '0) begin
        if (sb.size() == 0) begin
          chk("unexp_done", 32'({ack, err}), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          mon_v = 32'(1) << mon_e.idx;
          chk("ack", 32'(ack), mon_e.is_err ? 32'd0 : mon_v);
          chk("err", 32'(err), mon_e.is_err ? mon_v : 32'd0);
          if (mon_e.m != 32'd0)
            chk("rdata", rdata & mon_e.m, mon_e.rd & mon_e.m);
          chk("we_cycles", 32'(we_cnt), 32'(mon_e.wc));
          if (mon_e.wc != 0)
            chk("we_val", 32'(last_we), 32'(mon_e.we));
        end
        for (int r = 0; r < NREQ; r++) begin
          if (ack[r] | err[r]) begin
            if (hold_cnt[r] > 1) hold_cnt[r]--;
            else begin
              hold_cnt[r] = 0;
              req[r] = 1'b0;
            end
          end
        end
        we_cnt = 0;
      end else begin
        chk("rdata_idle", rdata, 32'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    ram[4] <= 8'hEF;
    ram[5] <= 8'hBE;
    ram[6] <= 8'hAD;
    ram[7] <= 8'hDE;
    req = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    for (int r = 0; r < NREQ; r++) hold_cnt[r] = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_mwe", 32'(mem_write_enable), 32'd0);
    chk("rst_mdin", mem_data_in, 32'd0);

    // Both writers held high out of reset: expect 0,1,0,1.
    sb_push(0, 0, 32'd0, 32'd0, 3'b001, 1);
    sb_push(1, 0, 32'd0, 32'd0, 3'b001, 1);
    sb_push(0, 0, 32'd0, 32'd0, 3'b001, 1);
    sb_push(1, 0, 32'd0, 32'd0, 3'b001, 1);
    issue(0, 3'b001, 32'h1000_0010, 32'h1111_1111, 2);
    issue(1, 3'b001, 32'h1000_0020, 32'h2222_2222, 2);
    @(negedge clk);
    rst = 1'b0;
    wait_empty(60);
    xact(0, 3'b000, 32'h1000_0010, 32'd0, 0, 32'h1111_1111, '1, 0);
    xact(1, 3'b000, 32'h1000_0020, 32'd0, 0, 32'h2222_2222, '1, 0);

    // Single read with exact latency.
    @(negedge clk);
    sb_push(0, 0, 32'hDEAD_BEEF, '1, 3'b000, 0);
    issue(0, 3'b000, 32'h1000_0004, 32'd0, 1);
    @(posedge clk);
    #1;
    chk("rd_busy", 32'(busy), 32'd1);
    chk("rd_maddr", mem_addr, 32'h1000_0004);
    chk("rd_mwe", 32'(mem_write_enable), 32'd0);
    @(posedge clk);
    #1;
    chk("rd_ack", 32'(ack), 32'd1);
    chk("rd_data", rdata, 32'hDEAD_BEEF);
    wait_empty(20);

    xact(1, 3'b100, 32'h1000_0001, 32'h0000_00AB, 0, 32'd0, 32'd0, 1);
    xact(1, 3'b000, 32'h1000_0001, 32'd0, 0, 32'h0000_00AB, 32'hFF, 0);
    xact(0, 3'b010, 32'h1000_0008, 32'h0000_CAFE, 0, 32'd0, 32'd0, 1);
    xact(0, 3'b000, 32'h1000_0008, 32'd0, 0, 32'h0000_CAFE, '1, 0);

    xact(1, 3'b001, 32'h1000_0002, 32'hFFFF_FFFF, 1, 32'd0, '1, 0);
    xact(1, 3'b000, 32'h5000_0000, 32'd0, 1, 32'd0, '1, 0);
    xact(0, 3'b000, 32'h4000_0000, 32'd0, 1, 32'd0, '1, 0);
    xact(1, 3'b010, 32'h1000_0009, 32'h0000_1234, 1, 32'd0, '1, 0);
    xact(1, 3'b011, 32'h1000_000C, 32'h5555_5555, 1, 32'd0, '1, 0);
    xact(1, 3'b000, 32'h3000_000C, 32'd0, 0, 32'd0, '1, 0);
    xact(1, 3'b000, 32'h1000_0003, 32'd0, 0, 32'hADBE_EF00, '1, 0);
    xact(0, 3'b000, 32'h1000_0000, 32'd0, 0, 32'h0000_AB00, '1, 0);

    // Reset in the middle of a write's ACCESS cycle.
    @(negedge clk);
    issue(0, 3'b001, 32'h1000_0040, 32'h1234_5678, 1);
    @(posedge clk);
    #1;
    chk("abort_we_on", 32'(mem_write_enable), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_we_off", 32'(mem_write_enable), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    req[0] = 1'b0;
    hold_cnt[0] = 0;
    @(negedge clk);
    chk("abort_done", 32'({ack, err}), 32'd0);
    sb_push(0, 0, 32'h1111_1111, '1, 3'b000, 0);
    sb_push(1, 0, 32'h2222_2222, '1, 3'b000, 0);
    issue(0, 3'b000, 32'h1000_0010, 32'd0, 1);
    issue(1, 3'b000, 32'h1000_0020, 32'd0, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_empty(40);
    xact(1, 3'b000, 32'h1000_0040, 32'd0, 0, 32'd0, '1, 0);

    // Requester 0 drops req right after its grant.
    @(negedge clk);
    sb_push(0, 0, 32'hDEAD_BEEF, '1, 3'b000, 0);
    sb_push(1, 0, 32'h0000_CAFE, '1, 3'b000, 0);
    issue(0, 3'b000, 32'h1000_0004, 32'd0, 1);
    issue(1, 3'b000, 32'h1000_0008, 32'd0, 1);
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    hold_cnt[0] = 0;
    wait_empty(40);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
